axi_mem_responder: RTL and testbench

- AXI-style memory slave that terminates the core's top-level read and write channels (AW/W/B/AR/R).
- It is the responder for the initiator formed by the memory arbiter.
- Provides a word-addressed backing store with incrementing bursts and a programmable read latency.
- Used as the memory model in simulation benches and FPGA self-test builds.

---
 rtl/axi_mem_responder_if.sv | 50 +++++
 rtl/axi_mem_responder.sv | 214 +++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_responder_if.sv
// AW/W/B/AR/R channel bundle between the memory arbiter (master) and the memory responder (slave).
// Width parameters must match the responder instance that the bundle connects to.
interface axi_mem_responder_if #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32
);
    logic                  AWREADY;
    logic                  AWVALID;
    logic [3:0]            AWID;
    logic [3:0]            AWLEN;
    logic [ADDR_WIDTH-1:0] AWADDR;

    logic                  WREADY;
    logic                  WVALID;
    logic                  WLAST;
    logic [3:0]            WID;
    logic [DATA_WIDTH-1:0] WDATA;

    logic                  BREADY;
    logic                  BVALID;
    logic [3:0]            BID;

    logic                  ARREADY;
    logic                  ARVALID;
    logic [3:0]            ARID;
    logic [3:0]            ARLEN;
    logic [ADDR_WIDTH-1:0] ARADDR;

    logic                  RREADY;
    logic                  RVALID;
    logic                  RLAST;
    logic [3:0]            RID;
    logic [DATA_WIDTH-1:0] RDATA;

    modport slave (
        output AWREADY, input AWVALID, input AWID, input AWLEN, input AWADDR,
        output WREADY,  input WVALID,  input WLAST, input WID, input WDATA,
        input  BREADY,  output BVALID, output BID,
        output ARREADY, input ARVALID, input ARID, input ARLEN, input ARADDR,
        input  RREADY,  output RVALID, output RLAST, output RID, output RDATA
    );

    modport master (
        input  AWREADY, output AWVALID, output AWID, output AWLEN, output AWADDR,
        input  WREADY,  output WVALID,  output WLAST, output WID, output WDATA,
        output BREADY,  input  BVALID,  input  BID,
        input  ARREADY, output ARVALID, output ARID, output ARLEN, output ARADDR,
        output RREADY,  input  RVALID,  input  RLAST, input RID, input RDATA
    );
endinterface

// File: rtl/axi_mem_responder.sv
// Word-addressed AXI-style memory slave with incrementing bursts and programmable read latency.
// Define AXI_MEM_BACKPRESSURE_EN to insert LFSR-driven WREADY/RVALID bubbles.
//
// state   | meaning
// R_IDLE  | ARREADY high, waiting for a read address
// R_WAIT  | counting down the read latency
// R_BURST | presenting read beats until the last one is accepted
// W_IDLE  | AWREADY high, waiting for a write address
// W_DATA  | accepting write beats into the store
// W_RESP  | holding BVALID until BREADY
module axi_mem_responder #(
    parameter int ADDR_WIDTH   = 26,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH_LOG2   = 12,
    parameter int READ_LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_mem_responder_if.slave   bus,
    output logic                 protocol_err
);
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef logic [DEPTH_LOG2-1:0] idx_t;

    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];

    rstate_t               rstate_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [3:0]            rlen_q;
    logic [3:0]            rbeat_q;
    logic [3:0]            rcnt_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic                  rlast_q;
    logic [3:0]            rid_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    wstate_t               wstate_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [3:0]            wlen_q;
    logic [3:0]            wbeat_q;
    logic [3:0]            wid_q;
    logic                  awready_q;
    logic                  wready_q;
    logic                  bvalid_q;
    logic [3:0]            bid_q;
    logic                  err_q;

    logic stall;
    logic w_hs;
    idx_t ridx_nxt;

`ifdef AXI_MEM_BACKPRESSURE_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    assign w_hs     = bus.WVALID && wready_q;
    assign ridx_nxt = raddr_q[DEPTH_LOG2-1:0] + idx_t'(1);

    // The store has no reset; a reset only abandons bursts in flight.
    always_ff @(posedge clk) begin
        if (!rst && w_hs) begin
            mem_q[waddr_q[DEPTH_LOG2-1:0]] <= bus.WDATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q  <= R_IDLE;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
            rcnt_q    <= '0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (bus.ARVALID && arready_q) begin
                        rid_q     <= bus.ARID;
                        raddr_q   <= bus.ARADDR;
                        rlen_q    <= bus.ARLEN;
                        rbeat_q   <= '0;
                        rcnt_q    <= 4'(READ_LATENCY - 1);
                        arready_q <= 1'b0;
                        rstate_q  <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (rcnt_q == 4'd0) begin
                        rstate_q <= R_BURST;
                        if (!stall) begin
                            rvalid_q <= 1'b1;
                            rdata_q  <= mem_q[raddr_q[DEPTH_LOG2-1:0]];
                            rlast_q  <= (rlen_q == 4'd0);
                        end
                    end else begin
                        rcnt_q <= rcnt_q - 4'd1;
                    end
                end
                R_BURST: begin
                    if (rvalid_q) begin
                        if (bus.RREADY) begin
                            if (rbeat_q == rlen_q) begin
                                rvalid_q  <= 1'b0;
                                rlast_q   <= 1'b0;
                                arready_q <= 1'b1;
                                rstate_q  <= R_IDLE;
                            end else begin
                                raddr_q  <= raddr_q + 1'b1;
                                rbeat_q  <= rbeat_q + 4'd1;
                                rvalid_q <= !stall;
                                rdata_q  <= mem_q[ridx_nxt];
                                rlast_q  <= !stall && (rbeat_q + 4'd1 == rlen_q);
                            end
                        end
                    end else if (!stall) begin
                        // Fetch at raise time so a withheld beat sees any write committed meanwhile.
                        rvalid_q <= 1'b1;
                        rdata_q  <= mem_q[raddr_q[DEPTH_LOG2-1:0]];
                        rlast_q  <= (rbeat_q == rlen_q);
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q  <= W_IDLE;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wbeat_q   <= '0;
            wid_q     <= '0;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (bus.AWVALID && awready_q) begin
                        wid_q     <= bus.AWID;
                        waddr_q   <= bus.AWADDR;
                        wlen_q    <= bus.AWLEN;
                        wbeat_q   <= '0;
                        awready_q <= 1'b0;
                        wready_q  <= !stall;
                        wstate_q  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        if ((bus.WID != wid_q) || (bus.WLAST != (wbeat_q == wlen_q))) begin
                            err_q <= 1'b1;
                        end
                        // Burst length is taken from AWLEN; WLAST only feeds the error flag.
                        if (wbeat_q == wlen_q) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= wid_q;
                            wstate_q <= W_RESP;
                        end else begin
                            waddr_q  <= waddr_q + 1'b1;
                            wbeat_q  <= wbeat_q + 4'd1;
                            wready_q <= !stall;
                        end
                    end else begin
                        wready_q <= !stall;
                    end
                end
                W_RESP: begin
                    if (bus.BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    assign bus.ARREADY  = arready_q;
    assign bus.RVALID   = rvalid_q;
    assign bus.RLAST    = rlast_q;
    assign bus.RID      = rid_q;
    assign bus.RDATA    = rdata_q;
    assign bus.AWREADY  = awready_q;
    assign bus.WREADY   = wready_q;
    assign bus.BVALID   = bvalid_q;
    assign bus.BID      = bid_q;
    assign protocol_err = err_q;
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder in its default build (READ_LATENCY=4, no backpressure LFSR).
module tb_axi_mem_responder;
    logic clk;
    logic rst;
    logic protocol_err;

    int checks = 0;
    int errors = 0;
    logic exp_err;
    logic [31:0] wd [16];
    logic [31:0] ed [16];

    axi_mem_responder_if #(.ADDR_WIDTH(26), .DATA_WIDTH(32)) bus ();

    axi_mem_responder #(
        .ADDR_WIDTH(26), .DATA_WIDTH(32), .DEPTH_LOG2(12), .READ_LATENCY(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [3:0] wid, input logic [25:0] addr,
                               input logic [3:0] len, input logic [15:0] wlast_pat);
        int n;
        bus.AWVALID = 1'b1;
        bus.AWID    = id;
        bus.AWADDR  = addr;
        bus.AWLEN   = len;
        n = 0;
        while (!bus.AWREADY && n < 20) begin step(); n++; end
        chk("aw_wait", bus.AWREADY, 1);
        step();
        bus.AWVALID = 1'b0;
        chk("awready_busy", bus.AWREADY, 0);
        for (int i = 0; i <= int'(len); i++) begin
            bus.WVALID = 1'b1;
            bus.WID    = wid;
            bus.WDATA  = wd[i];
            bus.WLAST  = wlast_pat[i];
            n = 0;
            while (!bus.WREADY && n < 20) begin step(); n++; end
            chk("w_wait", bus.WREADY, 1);
            step();
            if ((wlast_pat[i] != (i == int'(len))) || (wid != id)) exp_err = 1'b1;
            chk("protocol_err", protocol_err, exp_err);
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        chk("bvalid", bus.BVALID, 1);
        chk("bid", bus.BID, id);
        chk("wready_resp", bus.WREADY, 0);
        step();
        chk("bvalid_held", bus.BVALID, 1);
        bus.BREADY = 1'b1;
        step();
        bus.BREADY = 1'b0;
        chk("bvalid_clear", bus.BVALID, 0);
        chk("awready_back", bus.AWREADY, 1);
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [25:0] addr, input logic [3:0] len,
                              input logic [15:0] rr_pat);
        int n;
        int beat;
        int cyc;
        bus.ARVALID = 1'b1;
        bus.ARID    = id;
        bus.ARADDR  = addr;
        bus.ARLEN   = len;
        chk("arready_idle", bus.ARREADY, 1);
        step();
        bus.ARVALID = 1'b0;
        chk("arready_busy", bus.ARREADY, 0);
        n = 0;
        while (!bus.RVALID && n < 20) begin step(); n++; end
        chk("read_latency", n, 4);
        beat = 0;
        cyc  = 0;
        while (beat <= int'(len) && cyc < 64) begin
            chk("rvalid", bus.RVALID, 1);
            chk("rdata", bus.RDATA, ed[beat]);
            chk("rlast", bus.RLAST, (beat == int'(len)));
            chk("rid", bus.RID, id);
            bus.RREADY = rr_pat[cyc % 16];
            step();
            if (bus.RREADY) beat++;
            bus.RREADY = 1'b0;
            cyc++;
        end
        chk("beats_done", beat, int'(len) + 1);
        chk("rvalid_end", bus.RVALID, 0);
        chk("arready_end", bus.ARREADY, 1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        exp_err = 1'b0;
        bus.AWVALID = 0; bus.AWID = 0; bus.AWLEN = 0; bus.AWADDR = 0;
        bus.WVALID = 0; bus.WLAST = 0; bus.WID = 0; bus.WDATA = 0;
        bus.BREADY = 0;
        bus.ARVALID = 0; bus.ARID = 0; bus.ARLEN = 0; bus.ARADDR = 0;
        bus.RREADY = 0;
        step(); step(); step();
        rst = 1'b0;
        step();

        chk("rst_awready", bus.AWREADY, 1);
        chk("rst_arready", bus.ARREADY, 1);
        chk("rst_wready", bus.WREADY, 0);
        chk("rst_bvalid", bus.BVALID, 0);
        chk("rst_rvalid", bus.RVALID, 0);
        chk("rst_rlast", bus.RLAST, 0);
        chk("rst_err", protocol_err, 0);
        chk("rst_bid", bus.BID, 0);
        chk("rst_rid", bus.RID, 0);
        chk("rst_rdata", bus.RDATA, 0);

        // W data offered before any AW must be held off.
        bus.WVALID = 1'b1;
        bus.WDATA  = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("w_before_aw", bus.WREADY, 0);
        end
        bus.WVALID = 1'b0;

        // Single write then read.
        wd[0] = 32'hDEAD_BEEF;
        write_burst(4'h5, 4'h5, 26'h10, 4'd0, 16'h0001);
        ed[0] = 32'hDEAD_BEEF;
        read_burst(4'h3, 26'h10, 4'd0, 16'hFFFF);

        // Four-beat burst, full-rate read.
        wd[0] = 32'h1; wd[1] = 32'h2; wd[2] = 32'h3; wd[3] = 32'h4;
        write_burst(4'hA, 4'hA, 26'h20, 4'd3, 16'h0008);
        ed[0] = 32'h1; ed[1] = 32'h2; ed[2] = 32'h3; ed[3] = 32'h4;
        read_burst(4'h7, 26'h20, 4'd3, 16'hFFFF);

        // Same burst with RREADY pattern 1,0,0,1,...
        read_burst(4'h8, 26'h20, 4'd3, 16'b1001_0010_0100_1001);

        // Wrap past the top of the store, and upper-bit aliasing.
        wd[0] = 32'hA; wd[1] = 32'hB;
        write_burst(4'h2, 4'h2, 26'd4095, 4'd1, 16'h0002);
        ed[0] = 32'hB;
        read_burst(4'h1, 26'd0, 4'd0, 16'hFFFF);
        ed[0] = 32'hA;
        read_burst(4'h1, 26'd4095, 4'd0, 16'hFFFF);
        ed[0] = 32'hA; ed[1] = 32'hB;
        read_burst(4'h4, 26'd4095, 4'd1, 16'hFFFF);
        ed[0] = 32'hDEAD_BEEF;
        read_burst(4'h6, 26'h0001010, 4'd0, 16'hFFFF);

        // WLAST on beat 0 of a 3-beat burst, then missing on beat 2.
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33;
        write_burst(4'hC, 4'hC, 26'h40, 4'd2, 16'h0001);
        step();
        chk("err_sticky", protocol_err, 1);
        ed[0] = 32'h11; ed[1] = 32'h22; ed[2] = 32'h33;
        read_burst(4'h9, 26'h40, 4'd2, 16'hFFFF);

        // Reset while beat 1 of a read is being presented.
        bus.ARVALID = 1'b1; bus.ARID = 4'hE; bus.ARADDR = 26'h20; bus.ARLEN = 4'd3;
        step();
        bus.ARVALID = 1'b0;
        n = 0;
        while (!bus.RVALID && n < 20) begin step(); n++; end
        chk("mid_rvalid0", bus.RVALID, 1);
        bus.RREADY = 1'b1;
        step();
        bus.RREADY = 1'b0;
        chk("mid_beat1", bus.RDATA, 32'h2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_err = 1'b0;
        chk("mid_rst_rvalid", bus.RVALID, 0);
        chk("mid_rst_arready", bus.ARREADY, 1);
        chk("mid_rst_err", protocol_err, 0);
        ed[0] = 32'hDEAD_BEEF;
        read_burst(4'hF, 26'h10, 4'd0, 16'hFFFF);

        // Store survived the reset.
        ed[0] = 32'h1; ed[1] = 32'h2; ed[2] = 32'h3; ed[3] = 32'h4;
        read_burst(4'h0, 26'h20, 4'd3, 16'hFFFF);

        // WID mismatch flags an error even with correct WLAST.
        wd[0] = 32'h55;
        write_burst(4'h3, 4'h4, 26'h50, 4'd0, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
